// File: rtl/store_align_unit.sv
// Store aligner: byte-addressed SB/SH/SW into word-addressed beats with byte enables.
// Latency: first beat registered 1 cycle after accept; a word-crossing store takes a second beat.
// Backpressure: mem_* hold while mem_ready is low; req_ready only in IDLE or on an accepted final beat.
module store_align_unit #(
    parameter int ADDR_W           = 10,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_type,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign_err
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t state, state_n;

    logic [1:0]        off;
    logic [6:0]        size_mask;
    logic [6:0]        mask;
    logic              split_req;
    logic              reject;
    logic [5:0]        lo_shift;
    logic [5:0]        hi_shift;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic [ADDR_W-1:0] word;
    logic              unused_addr_bits;

    logic              split_q;
    logic [ADDR_W-1:0] b1_addr;
    logic [3:0]        b1_we;
    logic [31:0]       b1_wdata;
    logic              err_pending;

    logic              final_beat;
    logic              final_acc;
    logic              accept;
    logic              good_acc;
    logic              rej_acc;

    assign off              = req_addr[1:0];
    assign word             = req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        size_mask = 7'b0000000;
        case (req_type)
            2'b00:   size_mask = 7'b0000001;
            2'b01:   size_mask = 7'b0000011;
            2'b10:   size_mask = 7'b0001111;
            default: size_mask = 7'b0000000;
        endcase
    end

    assign mask      = size_mask << off;
    assign split_req = |mask[6:4];
    assign reject    = (req_type == 2'b11) || ((ALLOW_MISALIGNED == 1'b0) && split_req);
    assign lo_shift  = {1'b0, off, 3'b000};
    assign hi_shift  = 6'd32 - lo_shift;
    assign wdata0    = req_data << lo_shift;
    assign wdata1    = req_data >> hi_shift;

    // mem_valid is a pure decode of the registered state, so it drops as soon as reset asserts.
    assign busy       = (state != IDLE);
    assign mem_valid  = busy;
    assign final_beat = ((state == BEAT0) && !split_q) || (state == BEAT1);
    assign final_acc  = final_beat && mem_valid && mem_ready;
    assign req_ready  = (state == IDLE) || final_acc;
    assign accept     = req_valid && req_ready;
    assign good_acc   = accept && !reject;
    assign rej_acc    = accept && reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (good_acc) state_n = BEAT0;
            BEAT0: if (mem_ready) state_n = split_q ? BEAT1 : (good_acc ? BEAT0 : IDLE);
            BEAT1: if (mem_ready) state_n = good_acc ? BEAT0 : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= '0;
            mem_we       <= 4'b0000;
            mem_wdata    <= 32'h0;
            split_q      <= 1'b0;
            b1_addr      <= '0;
            b1_we        <= 4'b0000;
            b1_wdata     <= 32'h0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
            err_pending  <= 1'b0;
        end else begin
            done <= final_acc;
            // A reject accepted alongside a final beat, or behind a pending one, slips a
            // cycle so done and misalign_err never share a cycle and no pulse is lost.
            misalign_err <= err_pending || (rej_acc && !final_acc);
            err_pending  <= rej_acc && (final_acc || err_pending);
            if (good_acc) begin
                mem_addr  <= word;
                mem_we    <= mask[3:0];
                mem_wdata <= wdata0;
                b1_addr   <= word + {{(ADDR_W-1){1'b0}}, 1'b1};
                b1_we     <= {1'b0, mask[6:4]};
                b1_wdata  <= wdata1;
                split_q   <= split_req;
            end else if ((state == BEAT0) && mem_ready && split_q) begin
                mem_addr  <= b1_addr;
                mem_we    <= b1_we;
                mem_wdata <= b1_wdata;
                split_q   <= 1'b0;
            end else if (final_acc) begin
                mem_we    <= 4'b0000;
            end
        end
    end

endmodule
